mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 2, memory access cycles (legal 1..7).
REQ-002 SHALL have parameter MAX_DATA_RUN, default 4, consecutive data grants allowed while fetch waits (legal 1..15).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port if_req  in  1  fetch read request, held until if_ready.
REQ-006 SHALL have port if_addr  in  32  fetch byte address.
REQ-007 SHALL have port if_rdata  out  32  fetch read data, valid with if_ready.
REQ-008 SHALL have port if_ready  out  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port dm_req  in  1  data request, held until dm_ready.
REQ-010 SHALL have port dm_we  in  1  data write enable (1 = write).
REQ-011 SHALL have port dm_addr  in  32  data byte address.
REQ-012 SHALL have port dm_wdata  in  32  data write value.
REQ-013 SHALL have port dm_rdata  out  32  data read value, valid with dm_ready.
REQ-014 SHALL have port dm_ready  out  1  one-cycle data completion pulse.
REQ-015 SHALL have ports stall_if, stall_mem  out  1 each  pipeline stall = req & ~ready per requester (combinational).
REQ-016 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out 30 (word address), mem_wdata out 32, mem_rdata in 32  unified single-port memory.

Function
REQ-017 SHALL implement FSM IDLE, ACCESS, RESP.
REQ-018 IDLE: if any request, grant one, latch owner/we/addr[31:2]/wdata, load counter with LATENCY-1, go ACCESS next edge; else stay.
REQ-019 Arbitration SHALL favour data, except fetch wins when if_req=1 and data_run == MAX_DATA_RUN.
REQ-020 data_run (4 bits) SHALL increment, saturating at MAX_DATA_RUN, on each data grant and clear on each fetch grant.
REQ-021 ACCESS: mem_en=1 and mem_addr/mem_we/mem_wdata SHALL drive latched values, stable for all LATENCY cycles; mem_we=0 for fetch.
REQ-022 ACCESS: counter decrements each cycle; at counter==0 capture mem_rdata into response register, go RESP.
REQ-023 RESP: owner's ready=1 for exactly one cycle with captured data; go IDLE; mem_en=0.
REQ-024 Request-to-ready latency SHALL be LATENCY+2 cycles; back-to-back grants SHALL have one IDLE cycle between RESP and next ACCESS.
REQ-025 Write accesses SHALL also pulse dm_ready; dm_rdata then holds the value read during the write cycle (don't-care).
REQ-026 if_rdata/dm_rdata SHALL hold their last value until that requester's next completion.
REQ-027 A request dropped mid-access SHALL not abort it; access completes and ready pulses regardless.
REQ-028 Input changes during ACCESS SHALL not affect the memory-side signals.
REQ-029 addr[1:0] SHALL be ignored (word accesses only).
REQ-030 The non-granted requester SHALL see its stall held high until its own ready.

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE, mem_en=0, mem_we=0, if_ready=0, dm_ready=0, data_run=0, counter=0, if_rdata=0, dm_rdata=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset mid-ACCESS SHALL abandon the access without any ready pulse; first grant after release follows REQ-018.

Verification
REQ-033 Fetch only, LATENCY=2, if_addr=0x20, memory word 8 = 0x20020005 -> mem_en high 2 cycles with mem_addr=8, if_ready one cycle on cycle 4 after request, if_rdata=0x20020005.
REQ-034 Simultaneous if_req and dm_req write (dm_addr=84, dm_wdata=7) -> data granted first, mem_we=1 mem_addr=21 mem_wdata=7, dm_ready then fetch completes 1 IDLE cycle later; stall_if high throughout.
REQ-035 dm_req and if_req held continuously, MAX_DATA_RUN=4 -> grant order D,D,D,D,F,D,D,D,D,F.
REQ-036 reset_n pulled low during ACCESS of a write to addr 80 -> mem_en, mem_we drop immediately; no dm_ready; after release re-issued request completes normally in LATENCY+2 cycles.
REQ-037 dm_req dropped during ACCESS, LATENCY=7 -> mem_en stays high 7 cycles, dm_ready still pulses once, arbiter returns to IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between an instruction-fetch requester and a
// data requester. Each access walks IDLE -> ACCESS (LATENCY cycles) -> RESP.
// Data is preferred. Fetch still gets through once MAX_DATA_RUN data grants
// have been issued back to back while fetch is waiting.
//
// Ports
//   clk, reset_n          clock; asynchronous active-low reset
//   if_req/if_addr        fetch request and byte address
//   if_rdata/if_ready     fetch read data and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata  data request, write enable, address, write data
//   dm_rdata/dm_ready     data read value and one-cycle completion pulse
//   stall_if, stall_mem   request pending and not yet completed (combinational)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory side (word address)
module mem_port_arbiter #(
  parameter int LATENCY      = 2,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);
  localparam logic [3:0] RUN_MAX  = 4'(MAX_DATA_RUN);

  state_t      state_q, state_d;
  logic        owner_dm_q, owner_dm_d;   // 1 = data requester owns the access
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  run_q, run_d;             // consecutive data grants
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        grant_dm;

  // Data wins unless fetch is waiting and data has used its full run.
  assign grant_dm = dm_req && !(if_req && (run_q == RUN_MAX));

  always_comb begin
    state_d    = state_q;
    owner_dm_d = owner_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    run_d      = run_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          state_d    = ST_ACCESS;
          owner_dm_d = grant_dm;
          cnt_d      = CNT_LOAD;
          if (grant_dm) begin
            we_d    = dm_we;
            addr_d  = dm_addr[31:2];
            wdata_d = dm_wdata;
            run_d   = (run_q == RUN_MAX) ? run_q : run_q + 4'd1;
          end else begin
            we_d   = 1'b0;
            addr_d = if_addr[31:2];
            run_d  = 4'd0;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_RESP;
          // Each requester keeps its own read register so the other side's
          // completions never disturb it.
          if (owner_dm_q) dm_rdata_d = mem_rdata;
          else            if_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      owner_dm_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      run_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_dm_q <= owner_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Memory-side signals come only from latched values, so requester inputs
  // can change freely while an access is in flight.
  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_ready  = (state_q == ST_RESP) && !owner_dm_q;
  assign dm_ready  = (state_q == ST_RESP) &&  owner_dm_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  assign stall_if  = if_req && !if_ready;
  assign stall_mem = dm_req && !dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int LAT7 = 7;

  typedef struct packed {
    logic        is_fetch;
    logic        is_write;
    logic [31:0] data;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic        if_ready, dm_ready, stall_if, stall_mem, mem_en, mem_we;
  logic [29:0] mem_addr;

  logic        dm_req_7 = 1'b0;
  logic [31:0] dm_addr_7 = '0;
  logic [31:0] if_rdata_7, dm_rdata_7, mem_wdata_7, mem_rdata_7;
  logic        if_ready_7, dm_ready_7, stall_if_7, stall_mem_7, mem_en_7, mem_we_7;
  logic [29:0] mem_addr_7;

  int n_checks = 0;
  int n_errors = 0;
  sb_t sb_q[$];

  function automatic logic [31:0] init_word(input logic [5:0] a);
    return (a == 6'd8) ? 32'h2002_0005 : (32'hA500_0000 | {26'd0, a});
  endfunction

  // Memory model for the default instance: unwritten words read init_word.
  logic [31:0] mem_arr [64];
  logic [63:0] mem_wr;
  always @(posedge clk) begin
    if (!reset_n) mem_wr <= '0;
    else if (mem_en && mem_we) begin
      mem_arr[mem_addr[5:0]] <= mem_wdata;
      mem_wr[mem_addr[5:0]]  <= 1'b1;
    end
  end
  always_comb begin
    mem_rdata = init_word(mem_addr[5:0]);
    if (mem_wr[mem_addr[5:0]] === 1'b1) mem_rdata = mem_arr[mem_addr[5:0]];
  end
  assign mem_rdata_7 = init_word(mem_addr_7[5:0]);

  mem_port_arbiter #(.LATENCY(LAT), .MAX_DATA_RUN(4)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.LATENCY(LAT7), .MAX_DATA_RUN(4)) u_dut7 (
    .clk(clk), .reset_n(reset_n),
    .if_req(1'b0), .if_addr(32'd0), .if_rdata(if_rdata_7), .if_ready(if_ready_7),
    .dm_req(dm_req_7), .dm_we(1'b0), .dm_addr(dm_addr_7), .dm_wdata(32'd0),
    .dm_rdata(dm_rdata_7), .dm_ready(dm_ready_7),
    .stall_if(stall_if_7), .stall_mem(stall_mem_7),
    .mem_en(mem_en_7), .mem_we(mem_we_7), .mem_addr(mem_addr_7),
    .mem_wdata(mem_wdata_7), .mem_rdata(mem_rdata_7)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_en, mem_we, if_ready, dm_ready} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_en, mem_we, if_ready, dm_ready});
    end
    n_checks++;
    if (if_rdata !== 32'd0 || dm_rdata !== 32'd0) begin
      n_errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, dm_rdata);
    end
    n_checks++;
    if (mem_addr !== 30'd0 || mem_wdata !== 32'd0) begin
      n_errors++; $display("FAIL reset_mem: got %h/%h expected 0/0", mem_addr, mem_wdata);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({stall_if, stall_mem, mem_en} !== 3'b000) begin
      n_errors++; $display("FAIL reset_idle: got %b expected 000", {stall_if, stall_mem, mem_en});
    end
    $display("test_reset done");
  endtask

  task automatic test_fetch();
    int en_cnt = 0, bad = 0, rdy_at = -1;
    sb_t e;
    sb_q.push_back('{is_fetch: 1'b1, is_write: 1'b0, data: 32'h2002_0005});
    if_req = 1'b1; if_addr = 32'h20;
    #1;
    n_checks++;
    if (stall_if !== 1'b1) begin n_errors++; $display("FAIL fetch_stall: got %b expected 1", stall_if); end
    for (int k = 1; k <= 20 && rdy_at < 0; k++) begin
      @(negedge clk);
      if (mem_en) begin en_cnt++; if (mem_addr !== 30'd8 || mem_we !== 1'b0) bad++; end
      if (if_ready || dm_ready) begin
        rdy_at = k; if_req = 1'b0;
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL fetch_sb: unexpected ready"); end
        else begin
          e = sb_q.pop_front();
          if (dm_ready || if_rdata !== e.data) begin
            n_errors++; $display("FAIL fetch_sb: got if_ready=%b data=%h expected fetch %h", if_ready, if_rdata, e.data);
          end
        end
      end
    end
    n_checks++;
    if (rdy_at != LAT + 1) begin n_errors++; $display("FAIL fetch_latency: got %0d expected %0d", rdy_at, LAT + 1); end
    n_checks++;
    if (en_cnt != LAT || bad != 0) begin
      n_errors++; $display("FAIL fetch_mem: got en_cycles=%0d bad=%0d expected %0d/0", en_cnt, bad, LAT);
    end
    @(negedge clk);
    n_checks++;
    if (if_ready !== 1'b0 || if_rdata !== 32'h2002_0005) begin
      n_errors++; $display("FAIL fetch_pulse: got ready=%b data=%h expected 0/20020005", if_ready, if_rdata);
    end
    $display("test_fetch: ready at cycle %0d, mem_en cycles %0d", rdy_at, en_cnt);
  endtask

  task automatic test_simultaneous();
    int wr_seen = 0, bad = 0, stall_bad = 0, dm_at = -1, if_at = -1, hold_bad = 0;
    sb_t e;
    sb_q.push_back('{is_fetch: 1'b0, is_write: 1'b1, data: 32'd0});
    sb_q.push_back('{is_fetch: 1'b1, is_write: 1'b0, data: init_word(6'd16)});
    if_req = 1'b1; if_addr = 32'h43;  // low bits ignored -> word 16
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd84; dm_wdata = 32'd7;
    for (int k = 1; k <= 30 && if_at < 0; k++) begin
      @(negedge clk);
      if (mem_en && mem_we) begin
        wr_seen++;
        if (mem_addr !== 30'd21 || mem_wdata !== 32'd7) bad++;
        dm_addr = 32'd0; dm_wdata = 32'hDEAD_BEEF;  // must not reach memory
      end
      if (mem_en && !mem_we && mem_addr !== 30'd16) bad++;
      if (if_req && !if_ready && stall_if !== 1'b1) stall_bad++;
      if (if_ready || dm_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL simul_sb: unexpected ready"); end
        else begin
          e = sb_q.pop_front();
          if ((if_ready && dm_ready) || if_ready !== e.is_fetch || (!e.is_write && if_rdata !== e.data)) begin
            n_errors++; $display("FAIL simul_sb: got if_ready=%b dm_ready=%b if_rdata=%h expected fetch=%b %h",
                                 if_ready, dm_ready, if_rdata, e.is_fetch, e.data);
          end
        end
      end
      if (dm_ready) begin
        dm_at = k; dm_req = 1'b0; dm_we = 1'b0;
        if (if_rdata !== 32'h2002_0005) hold_bad++;
      end
      if (if_ready) begin if_at = k; if_req = 1'b0; end
    end
    n_checks++;
    if (wr_seen != LAT || bad != 0) begin
      n_errors++; $display("FAIL simul_mem: got writes=%0d bad=%0d expected %0d/0", wr_seen, bad, LAT);
    end
    n_checks++;
    if (dm_at != LAT + 1 || if_at - dm_at != LAT + 2) begin
      n_errors++; $display("FAIL simul_order: got dm_at=%0d if_at=%0d expected %0d/%0d", dm_at, if_at, LAT + 1, 2 * LAT + 3);
    end
    n_checks++;
    if (stall_bad != 0 || hold_bad != 0) begin
      n_errors++; $display("FAIL simul_stall_hold: got stall_bad=%0d hold_bad=%0d expected 0/0", stall_bad, hold_bad);
    end
    n_checks++;
    if (mem_arr[21] !== 32'd7) begin n_errors++; $display("FAIL simul_write: got %h expected 7", mem_arr[21]); end
    $display("test_simultaneous: dm_ready at %0d, if_ready at %0d", dm_at, if_at);
  endtask

  task automatic test_fairness();
    int done = 0;
    string order = "";
    sb_t e;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) sb_q.push_back('{is_fetch: 1'b1, is_write: 1'b0, data: init_word(6'd3)});
      else            sb_q.push_back('{is_fetch: 1'b0, is_write: 1'b0, data: init_word(6'd2)});
    end
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0C; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h08;
    for (int k = 1; k <= 100 && done < 10; k++) begin
      @(negedge clk);
      if (if_ready || dm_ready) begin
        done++;
        order = {order, if_ready ? "F" : "D"};
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL fair_sb: unexpected ready"); end
        else begin
          e = sb_q.pop_front();
          if ((if_ready && dm_ready) || if_ready !== e.is_fetch ||
              (if_ready ? if_rdata : dm_rdata) !== e.data) begin
            n_errors++; $display("FAIL fair_sb #%0d: got fetch=%b data=%h expected fetch=%b data=%h",
                                 done, if_ready, if_ready ? if_rdata : dm_rdata, e.is_fetch, e.data);
          end
        end
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    n_checks++;
    if (done != 10) begin n_errors++; $display("FAIL fair_count: got %0d expected 10", done); end
    $display("test_fairness: grant order %s", order);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int found = 0, rdy_stray = 0, rdy_at = -1;
    sb_t e;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd80; dm_wdata = 32'h55;
    for (int k = 1; k <= 10 && found == 0; k++) begin
      @(negedge clk);
      if (mem_en && mem_we) found = 1;
    end
    n_checks++;
    if (found == 0 || mem_addr !== 30'd20) begin
      n_errors++; $display("FAIL rstmid_access: got found=%0d addr=%0d expected 1/20", found, mem_addr);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_drop: got en=%b we=%b expected 0/0", mem_en, mem_we);
    end
    repeat (2) begin
      @(negedge clk);
      if (dm_ready !== 1'b0) rdy_stray++;
    end
    reset_n = 1'b1;
    sb_q.push_back('{is_fetch: 1'b0, is_write: 1'b1, data: 32'd0});
    for (int k = 1; k <= 20 && rdy_at < 0; k++) begin
      @(negedge clk);
      if (if_ready || dm_ready) begin
        rdy_at = k; dm_req = 1'b0; dm_we = 1'b0;
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL rstmid_sb: unexpected ready"); end
        else begin
          e = sb_q.pop_front();
          if (if_ready !== e.is_fetch || dm_ready !== 1'b1) begin
            n_errors++; $display("FAIL rstmid_sb: got if_ready=%b dm_ready=%b expected data write", if_ready, dm_ready);
          end
        end
      end
    end
    n_checks++;
    if (rdy_stray != 0 || rdy_at != LAT + 1) begin
      n_errors++; $display("FAIL rstmid_latency: got stray=%0d ready_at=%0d expected 0/%0d", rdy_stray, rdy_at, LAT + 1);
    end
    $display("test_reset_mid: re-issued write ready at cycle %0d", rdy_at);
    @(negedge clk);
  endtask

  task automatic test_drop_mid();
    int en_cnt = 0, pulses = 0, rdy_at = -1, stray = 0;
    logic [31:0] got = '0;
    dm_req_7 = 1'b1; dm_addr_7 = 32'h14;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_en_7) begin en_cnt++; dm_req_7 = 1'b0; end
      if (dm_ready_7) begin pulses++; rdy_at = k; got = dm_rdata_7; end
      if (if_ready_7) stray++;
    end
    n_checks++;
    if (en_cnt != LAT7) begin n_errors++; $display("FAIL drop_en: got %0d expected %0d", en_cnt, LAT7); end
    n_checks++;
    if (pulses != 1 || stray != 0 || rdy_at != LAT7 + 1) begin
      n_errors++; $display("FAIL drop_ready: got pulses=%0d stray=%0d at=%0d expected 1/0/%0d", pulses, stray, rdy_at, LAT7 + 1);
    end
    n_checks++;
    if (got !== init_word(6'd5)) begin n_errors++; $display("FAIL drop_data: got %h expected %h", got, init_word(6'd5)); end
    n_checks++;
    if (mem_en_7 !== 1'b0 || stall_mem_7 !== 1'b0) begin
      n_errors++; $display("FAIL drop_idle: got en=%b stall=%b expected 0/0", mem_en_7, stall_mem_7);
    end
    $display("test_drop_mid: %0d access cycles, ready at %0d", en_cnt, rdy_at);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_fairness();
    test_reset_mid();
    test_drop_mid();
    n_checks++;
    if (sb_q.size() != 0) begin n_errors++; $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
